// File: rtl/jzjpcc_mmio_bank.sv
// jzjpcc_mmio_bank
//   Word-addressed MMIO register bank for the jzjpcc core. Each channel
//   provides a multi-stage input synchronizer, a byte-enabled output
//   register, a per-bit direction register and sticky per-bit change flags
//   (write-1-to-clear). Register map, selected by the top two address bits:
//     0 IN   (read-only, synchronized inputs)
//     1 OUT  (read/write)
//     2 DIR  (read/write, 1 = drive)
//     3 FLAG (read, write-1-to-clear on enabled bytes)
//
// Ports
//   clock          sole clock, rising edge
//   reset          synchronous, active-low
//   addr           {bank[1:0], channel[CH_W-1:0]}
//   readEnable     read request; data returned one cycle later
//   writeEnable    write request; takes effect at the sampling edge
//   byteEnable     per-byte write mask
//   writeData      write data
//   readData       registered read data (holds when idle)
//   readValid      one-cycle pulse after an accepted read
//   mmioInputs     external inputs, may be asynchronous
//   mmioOutputs    output registers
//   mmioDirection  per-bit direction registers
//   changePending  registered OR of every change flag
module jzjpcc_mmio_bank #(
  parameter int NUM_CHANNELS = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int SYNC_STAGES  = 2,
  localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int NUM_BYTES   = DATA_WIDTH / 8
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [CH_W+1:0]                         addr,
  input  logic                                    readEnable,
  input  logic                                    writeEnable,
  input  logic [NUM_BYTES-1:0]                    byteEnable,
  input  logic [DATA_WIDTH-1:0]                   writeData,
  output logic [DATA_WIDTH-1:0]                   readData,
  output logic                                    readValid,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mmioInputs,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mmioOutputs,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mmioDirection,
  output logic                                    changePending
);

  localparam logic [1:0] BANK_IN   = 2'd0;
  localparam logic [1:0] BANK_OUT  = 2'd1;
  localparam logic [1:0] BANK_DIR  = 2'd2;
  localparam logic [1:0] BANK_FLAG = 2'd3;

  // Arm counter must hold SYNC_STAGES+1.
  localparam int              ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_INIT = ARM_W'(SYNC_STAGES + 1);

  typedef logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] bank_t;

  // Address decode
  logic [1:0]      bank;
  logic [CH_W-1:0] ch_idx;
  assign bank   = addr[CH_W+1:CH_W];
  assign ch_idx = addr[CH_W-1:0];

  logic [DATA_WIDTH-1:0] byte_mask;
  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      byte_mask[b*8 +: 8] = {8{byteEnable[b]}};
    end
  end

  // State
  bank_t                  sync_q [SYNC_STAGES];
  bank_t                  sync_d [SYNC_STAGES];
  bank_t                  prev_q, prev_d;
  bank_t                  out_q, out_d;
  bank_t                  dir_q, dir_d;
  bank_t                  flag_q, flag_d;
  logic [ARM_W-1:0]       arm_q, arm_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   pending_q, pending_d;

  bank_t sync_last;
  logic  armed;
  assign sync_last = sync_q[SYNC_STAGES-1];
  assign armed     = (arm_q == '0);

  always_comb begin
    sync_d[0] = mmioInputs;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign prev_d = sync_last;
  assign arm_d  = armed ? arm_q : arm_q - ARM_W'(1);

  // Per-channel write/flag/read logic. A channel index that matches no
  // channel simply hits nothing: reads see zero and writes are dropped.
  logic [DATA_WIDTH-1:0] rd_word [NUM_CHANNELS];

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    logic                  ch_hit;
    logic                  wr_out, wr_dir, wr_flag;
    logic [DATA_WIDTH-1:0] clr_mask, set_mask, word;

    assign ch_hit  = (ch_idx == CH_W'(gi));
    assign wr_out  = writeEnable && ch_hit && (bank == BANK_OUT);
    assign wr_dir  = writeEnable && ch_hit && (bank == BANK_DIR);
    assign wr_flag = writeEnable && ch_hit && (bank == BANK_FLAG);

    assign out_d[gi] = wr_out ? ((out_q[gi] & ~byte_mask) | (writeData & byte_mask))
                              : out_q[gi];
    assign dir_d[gi] = wr_dir ? ((dir_q[gi] & ~byte_mask) | (writeData & byte_mask))
                              : dir_q[gi];

    // Set is applied after clear so a simultaneous edge on a bit keeps it set.
    assign clr_mask   = wr_flag ? (writeData & byte_mask) : '0;
    assign set_mask   = armed ? (sync_last[gi] ^ prev_q[gi]) : '0;
    assign flag_d[gi] = (flag_q[gi] & ~clr_mask) | set_mask;

    // Read sees the register values before this edge's write.
    always_comb begin
      word = '0;
      case (bank)
        BANK_IN:   word = sync_last[gi];
        BANK_OUT:  word = out_q[gi];
        BANK_DIR:  word = dir_q[gi];
        BANK_FLAG: word = flag_q[gi];
        default:   word = '0;
      endcase
    end
    assign rd_word[gi] = ch_hit ? word : '0;
  end

  always_comb begin
    logic [DATA_WIDTH-1:0] rd_any;
    rd_any = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rd_any = rd_any | rd_word[c];
    end
    rdata_d  = readEnable ? rd_any : rdata_q;
    rvalid_d = readEnable;
  end

  assign pending_d = |flag_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q    <= '0;
      out_q     <= '0;
      dir_q     <= '0;
      flag_q    <= '0;
      arm_q     <= ARM_INIT;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      prev_q    <= prev_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
      flag_q    <= flag_d;
      arm_q     <= arm_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      pending_q <= pending_d;
    end
  end

  assign readData      = rdata_q;
  assign readValid     = rvalid_q;
  assign mmioOutputs   = out_q;
  assign mmioDirection = dir_q;
  assign changePending = pending_q;

endmodule

// File: tb/tb_jzjpcc_mmio_bank.sv
// Bench for jzjpcc_mmio_bank: two instances (8 and 5 channels) share one
// request bus; a behavioural model of registers, input history and arming
// predicts every output after every edge.
module tb_jzjpcc_mmio_bank;

  localparam int S  = 2;
  localparam int NA = 8;
  localparam int NB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [4:0]          addr;
  logic                re, we;
  logic [3:0]          be;
  logic [31:0]         wd;
  logic [7:0][31:0]    mmio_in;

  logic [31:0]         rd_a, rd_b;
  logic                rv_a, rv_b, cp_a, cp_b;
  logic [7:0][31:0]    out_a, dir_a;
  logic [4:0][31:0]    out_b, dir_b;

  jzjpcc_mmio_bank #(.NUM_CHANNELS(NA), .DATA_WIDTH(32), .SYNC_STAGES(S)) dut_a (
    .clock(clk), .reset(rst_n), .addr(addr), .readEnable(re), .writeEnable(we),
    .byteEnable(be), .writeData(wd), .readData(rd_a), .readValid(rv_a),
    .mmioInputs(mmio_in), .mmioOutputs(out_a), .mmioDirection(dir_a),
    .changePending(cp_a)
  );

  jzjpcc_mmio_bank #(.NUM_CHANNELS(NB), .DATA_WIDTH(32), .SYNC_STAGES(S)) dut_b (
    .clock(clk), .reset(rst_n), .addr(addr), .readEnable(re), .writeEnable(we),
    .byteEnable(be), .writeData(wd), .readData(rd_b), .readValid(rv_b),
    .mmioInputs(mmio_in[4:0]), .mmioOutputs(out_b), .mmioDirection(dir_b),
    .changePending(cp_b)
  );

  // Reference model
  logic [31:0]      m_out  [2][8];
  logic [31:0]      m_dir  [2][8];
  logic [31:0]      m_flag [2][8];
  logic [31:0]      m_rd   [2];
  logic             m_rv   [2];
  logic             m_cp   [2];
  logic [7:0][31:0] hist   [S+1];  // hist[k] = inputs sampled k edges ago
  int               edges_since_reset;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic [1:0]  bank;
    int          ch, nch;
    logic [31:0] mask, clr, set;
    bit          armed;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 8; c++) begin
          m_out[d][c] = '0; m_dir[d][c] = '0; m_flag[d][c] = '0;
        end
        m_rd[d] = '0; m_rv[d] = 1'b0; m_cp[d] = 1'b0;
      end
      for (int k = 0; k <= S; k++) hist[k] = '0;
      edges_since_reset = 0;
      return;
    end
    bank  = addr[4:3];
    ch    = int'(addr[2:0]);
    armed = (edges_since_reset >= S + 1);
    for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{be[b]}};
    for (int d = 0; d < 2; d++) begin
      nch = (d == 0) ? NA : NB;
      if (re) begin
        m_rv[d] = 1'b1;
        if (ch < nch) begin
          case (bank)
            2'd0:    m_rd[d] = hist[S-1][ch];
            2'd1:    m_rd[d] = m_out[d][ch];
            2'd2:    m_rd[d] = m_dir[d][ch];
            default: m_rd[d] = m_flag[d][ch];
          endcase
        end else begin
          m_rd[d] = '0;
        end
      end else begin
        m_rv[d] = 1'b0;
      end
      m_cp[d] = 1'b0;
      for (int c = 0; c < nch; c++) begin
        set = armed ? (hist[S-1][c] ^ hist[S][c]) : 32'h0;
        clr = 32'h0;
        if (we && ch == c) begin
          if (bank == 2'd1) m_out[d][c] = (m_out[d][c] & ~mask) | (wd & mask);
          if (bank == 2'd2) m_dir[d][c] = (m_dir[d][c] & ~mask) | (wd & mask);
          if (bank == 2'd3) clr = wd & mask;
        end
        m_flag[d][c] = (m_flag[d][c] & ~clr) | set;
        if (m_flag[d][c] != 0) m_cp[d] = 1'b1;
      end
    end
    for (int k = S; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = mmio_in;
    if (edges_since_reset < 1000) edges_since_reset++;
  endtask

  task automatic tick();
    logic [255:0] eo, ed;
    @(posedge clk);
    model_step();
    #1;
    txn++;
    for (int d = 0; d < 2; d++) begin
      eo = '0; ed = '0;
      for (int c = 0; c < ((d == 0) ? NA : NB); c++) begin
        eo[c*32 +: 32] = m_out[d][c];
        ed[c*32 +: 32] = m_dir[d][c];
      end
      if (d == 0) begin
        check_eq("a_readValid", rv_a, m_rv[0]);
        check_eq("a_readData", rd_a, m_rd[0]);
        check_eq("a_outputs", out_a, eo);
        check_eq("a_direction", dir_a, ed);
        check_eq("a_pending", cp_a, m_cp[0]);
      end else begin
        check_eq("b_readValid", rv_b, m_rv[1]);
        check_eq("b_readData", rd_b, m_rd[1]);
        check_eq("b_outputs", out_b, eo);
        check_eq("b_direction", dir_b, ed);
        check_eq("b_pending", cp_b, m_cp[1]);
      end
    end
    $display("txn %0d rst_n=%b addr=%h re=%b we=%b be=%h wd=%h | a: rd=%h rv=%b cp=%b | b: rd=%h rv=%b cp=%b",
             txn, rst_n, addr, re, we, be, wd, rd_a, rv_a, cp_a, rd_b, rv_b, cp_b);
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    re = r; we = w; addr = a; wd = d; be = b;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
  endtask

  initial begin
    int ci, bi;

    // 1: reset with ch0 inputs high, then arming window
    rst_n = 1'b0; re = 1'b0; we = 1'b0; addr = '0; be = '0; wd = '0;
    mmio_in = '0;
    mmio_in[0] = 32'hFFFF_FFFF;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < S + 1; i++) begin
      idle();
      check_eq("t1_pending_arming", cp_a, 1'b0);
    end
    for (int i = 0; i < 3; i++) idle();
    drive(1'b1, 1'b0, {2'd0, 3'd0}, 32'h0, 4'h0);
    check_eq("t1_in_ch0", rd_a, 32'hFFFF_FFFF);
    check_eq("t1_in_valid", rv_a, 1'b1);
    drive(1'b1, 1'b0, {2'd3, 3'd0}, 32'h0, 4'h0);
    check_eq("t1_flag_ch0", rd_a, 32'h0);

    // 2: byte-enabled write
    drive(1'b0, 1'b1, {2'd1, 3'd3}, 32'h1234_5678, 4'b1111);
    drive(1'b0, 1'b1, {2'd1, 3'd3}, 32'hAABB_CCDD, 4'b0101);
    check_eq("t2_out3", out_a[3], 32'h12BB_56DD);
    drive(1'b1, 1'b0, {2'd1, 3'd3}, 32'h0, 4'h0);
    check_eq("t2_read", rd_a, 32'h12BB_56DD);
    check_eq("t2_valid", rv_a, 1'b1);
    idle();
    check_eq("t2_valid_drop", rv_a, 1'b0);
    check_eq("t2_read_hold", rd_a, 32'h12BB_56DD);

    // 3: change flags with W1C
    mmio_in[2] = 32'h0000_0081;
    for (int i = 0; i < S + 1; i++) idle();
    check_eq("t3_pending", cp_a, 1'b1);
    drive(1'b1, 1'b0, {2'd3, 3'd2}, 32'h0, 4'h0);
    check_eq("t3_flag", rd_a, 32'h0000_0081);
    drive(1'b0, 1'b1, {2'd3, 3'd2}, 32'h0000_0001, 4'hF);
    drive(1'b1, 1'b0, {2'd3, 3'd2}, 32'h0, 4'h0);
    check_eq("t3_flag_w1c", rd_a, 32'h0000_0080);
    check_eq("t3_pending_still", cp_a, 1'b1);
    drive(1'b0, 1'b1, {2'd3, 3'd2}, 32'h0000_0080, 4'hF);
    check_eq("t3_pending_clear", cp_a, 1'b0);

    // 4: set/clear collision on ch1 bit 0
    mmio_in[1][0] = 1'b1;
    for (int i = 0; i < S + 1; i++) idle();
    check_eq("t4_pre_pending", cp_a, 1'b1);
    mmio_in[1][0] = 1'b0;
    idle();
    for (int i = 0; i < S - 1; i++) idle();
    drive(1'b0, 1'b1, {2'd3, 3'd1}, 32'h0000_0001, 4'hF);
    drive(1'b1, 1'b0, {2'd3, 3'd1}, 32'h0, 4'h0);
    check_eq("t4_flag_kept", rd_a[0], 1'b1);
    drive(1'b0, 1'b1, {2'd3, 3'd1}, 32'h0000_0001, 4'hF);
    check_eq("t4_cleared", cp_a, 1'b0);

    // 5: read-during-write on DIR ch5
    drive(1'b1, 1'b1, {2'd2, 3'd5}, 32'hF0F0_F0F0, 4'hF);
    check_eq("t5_old_value", rd_a, 32'h0);
    check_eq("t5_dir5", dir_a[5], 32'hF0F0_F0F0);
    drive(1'b1, 1'b0, {2'd2, 3'd5}, 32'h0, 4'h0);
    check_eq("t5_new_value", rd_a, 32'hF0F0_F0F0);

    // 6: out-of-range channel on the 5-channel instance
    drive(1'b1, 1'b0, {2'd0, 3'd7}, 32'h0, 4'h0);
    check_eq("t6_oor_read", rd_b, 32'h0);
    check_eq("t6_oor_valid", rv_b, 1'b1);
    drive(1'b0, 1'b1, {2'd1, 3'd6}, 32'h5A5A_5A5A, 4'hF);
    check_eq("t6_oor_write", out_b, {32'h0, 32'h12BB_56DD, 96'h0});
    check_eq("t6_inrange_write", out_a[6], 32'h5A5A_5A5A);

    // Randomised traffic, input toggles and occasional reset
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 3) == 0) begin
        ci = $urandom_range(0, 7);
        bi = $urandom_range(0, 31);
        mmio_in[ci][bi] = ~mmio_in[ci][bi];
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
            32'($urandom), 4'($urandom));
    end
    rst_n = 1'b1;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
